// File: rtl/relu_pack_chn64_if.sv
// Stream bundle for relu_pack_chn64: final partial-sum words in, packed int8 beats out.
// The master drives partial sums and downstream ready; the slave is the packer.
interface relu_pack_chn64_if #(
    parameter int CHN    = 64,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 8,
    parameter int BEAT_W = 128
);
    logic [CHN*IN_W-1:0] part_sum_w;
    logic                part_sum_v_w;
    logic                final_out_v_w;
    logic [3:0]          shift_w;
    logic                in_ready_w;
    logic [BEAT_W-1:0]   relu_data_w;
    logic                relu_data_v_w;
    logic                relu_ready_w;
    logic                relu_last_w;

    modport master (
        output part_sum_w, part_sum_v_w, final_out_v_w, shift_w, relu_ready_w,
        input  in_ready_w, relu_data_w, relu_data_v_w, relu_last_w
    );

    modport slave (
        input  part_sum_w, part_sum_v_w, final_out_v_w, shift_w, relu_ready_w,
        output in_ready_w, relu_data_w, relu_data_v_w, relu_last_w
    );
endinterface

// File: rtl/relu_pack_chn64.sv
// ReLU + right-shift requantisation of 64 signed partial sums into saturated int8,
// streamed out as four 128-bit beats with valid/ready backpressure.
module relu_pack_chn64 #(
    parameter int CHN    = 64,
    parameter int IN_W   = 16,
    parameter int OUT_W  = 8,
    parameter int BEAT_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    relu_pack_chn64_if.slave bus,
    output logic             drop_err_w
);
    localparam int NBEAT = CHN * OUT_W / BEAT_W;
    localparam int IDX_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEAT - 1);

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t               state;
    logic [CHN*IN_W-1:0]  cap_data_p0;
    logic [3:0]           cap_shift_p0;
    logic [CHN*OUT_W-1:0] conv_flat;
    logic [CHN*OUT_W-1:0] conv_flat_p1;
    logic [BEAT_W-1:0]    conv_beats [NBEAT];
    logic [BEAT_W-1:0]    beats_p1   [NBEAT];
    logic [IDX_W-1:0]     beat_idx;
    logic [IDX_W-1:0]     nxt_idx;
    logic [BEAT_W-1:0]    data_p1;
    logic                 vld_p1;
    logic                 last_p1;
    logic                 final_in;
    logic                 capture;
    logic                 drop;

    // Negative or zero clamps to 0; positive values saturate at the int8 maximum.
    function automatic logic [OUT_W-1:0] relu_sat(input logic signed [IN_W-1:0] x,
                                                  input logic [3:0] sh);
        logic signed [IN_W-1:0] y;
        if (x[IN_W-1] || (x == '0)) return '0;
        y = x >>> sh;
        if (|y[IN_W-1:OUT_W-1]) return {1'b0, {(OUT_W-1){1'b1}}};
        return {1'b0, y[OUT_W-2:0]};
    endfunction

    for (genvar i = 0; i < CHN; i++) begin : g_ch
        assign conv_flat[i*OUT_W +: OUT_W] = relu_sat(cap_data_p0[i*IN_W +: IN_W], cap_shift_p0);
    end

    for (genvar k = 0; k < NBEAT; k++) begin : g_beat
        assign conv_beats[k] = conv_flat[k*BEAT_W +: BEAT_W];
        assign beats_p1[k]   = conv_flat_p1[k*BEAT_W +: BEAT_W];
    end

    assign final_in = bus.part_sum_v_w && bus.final_out_v_w;
    assign capture  = final_in && (state == IDLE);
    assign drop     = final_in && (state != IDLE);
    assign nxt_idx  = beat_idx + IDX_W'(1);

    assign bus.in_ready_w    = (state == IDLE);
    assign bus.relu_data_w   = data_p1;
    assign bus.relu_data_v_w = vld_p1;
    assign bus.relu_last_w   = last_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            beat_idx     <= '0;
            cap_data_p0  <= '0;
            cap_shift_p0 <= '0;
            conv_flat_p1 <= '0;
            data_p1      <= '0;
            vld_p1       <= 1'b0;
            last_p1      <= 1'b0;
            drop_err_w   <= 1'b0;
        end else begin
            if (drop) drop_err_w <= 1'b1;
            case (state)
                // p0: capture the final pass and its shift amount
                IDLE: begin
                    if (capture) begin
                        cap_data_p0  <= bus.part_sum_w;
                        cap_shift_p0 <= bus.shift_w;
                        state        <= CONV;
                    end
                end
                // p1: register the converted word and present beat 0 straight away
                CONV: begin
                    conv_flat_p1 <= conv_flat;
                    data_p1      <= conv_beats[0];
                    vld_p1       <= 1'b1;
                    last_p1      <= (NBEAT == 1);
                    beat_idx     <= '0;
                    state        <= SEND;
                end
                SEND: begin
                    if (vld_p1 && bus.relu_ready_w) begin
                        if (beat_idx == LAST_IDX) begin
                            data_p1  <= '0;
                            vld_p1   <= 1'b0;
                            last_p1  <= 1'b0;
                            beat_idx <= '0;
                            state    <= IDLE;
                        end else begin
                            data_p1  <= beats_p1[nxt_idx];
                            last_p1  <= (nxt_idx == LAST_IDX);
                            beat_idx <= nxt_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_relu_pack_chn64.sv
// Scoreboard bench for relu_pack_chn64: expected beats are queued when a final word is
// driven and popped as the packer hands them off downstream.
`timescale 1ns/1ps
module tb_relu_pack_chn64;
    localparam int CHN    = 64;
    localparam int IN_W   = 16;
    localparam int OUT_W  = 8;
    localparam int BEAT_W = 128;
    localparam int NBEAT  = 4;
    localparam logic [BEAT_W-1:0] ZERO = '0;
    localparam logic [BEAT_W-1:0] ONE  = BEAT_W'(1);

    typedef struct packed {
        logic [BEAT_W-1:0] d;
        logic              l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic drop_err_w;

    relu_pack_chn64_if #(.CHN(CHN), .IN_W(IN_W), .OUT_W(OUT_W), .BEAT_W(BEAT_W)) bus ();

    relu_pack_chn64 #(.CHN(CHN), .IN_W(IN_W), .OUT_W(OUT_W), .BEAT_W(BEAT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .drop_err_w (drop_err_w)
    );

    always #5 clk = ~clk;

    beat_t sb_q[$];
    int    n_cmp  = 0;
    int    n_mis  = 0;
    int    hs_cnt = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [BEAT_W-1:0] act,
                             input logic [BEAT_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic logic [CHN*OUT_W-1:0] model_word(input logic [CHN*IN_W-1:0] ps,
                                                        input int sh);
        logic [CHN*OUT_W-1:0] w;
        int x, y;
        w = '0;
        for (int c = 0; c < CHN; c++) begin
            x = int'($signed(ps[c*IN_W +: IN_W]));
            if (x <= 0) y = 0;
            else begin
                y = x / (1 << sh);
                if (y > 127) y = 127;
            end
            w[c*OUT_W +: OUT_W] = 8'(y);
        end
        return w;
    endfunction

    function automatic logic [CHN*IN_W-1:0] rand_ps();
        logic [CHN*IN_W-1:0] ps;
        for (int c = 0; c < CHN; c++) ps[c*IN_W +: IN_W] = 16'($urandom);
        return ps;
    endfunction

    task automatic push_word(input logic [CHN*IN_W-1:0] ps, input int sh);
        logic [CHN*OUT_W-1:0] w;
        beat_t b;
        w = model_word(ps, sh);
        for (int k = 0; k < NBEAT; k++) begin
            b.d = w[k*BEAT_W +: BEAT_W];
            b.l = (k == NBEAT - 1);
            sb_q.push_back(b);
        end
    endtask

    // Waits for in_ready, presents one final word for a cycle; cap = cycle of the capture edge.
    task automatic drive_word(input logic [CHN*IN_W-1:0] ps, input logic [3:0] sh,
                              output int cap);
        int tries;
        tries = 0;
        do begin
            @(posedge clk); #1;
            tries++;
        end while (!bus.in_ready_w && tries < 100);
        if (!bus.in_ready_w) check_val("in_ready_timeout", BEAT_W'(bus.in_ready_w), ONE);
        bus.part_sum_w    = ps;
        bus.shift_w       = sh;
        bus.part_sum_v_w  = 1'b1;
        bus.final_out_v_w = 1'b1;
        push_word(ps, int'(sh));
        @(posedge clk); #1;
        cap = cyc;
        bus.part_sum_v_w  = 1'b0;
        bus.final_out_v_w = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || bus.relu_data_v_w) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check_val("drain", BEAT_W'(sb_q.size()), ZERO);
    endtask

    // Every presented beat must match the scoreboard head; it is consumed on handshake.
    always @(negedge clk) begin
        if (bus.relu_data_v_w) begin
            if (sb_q.size() == 0) begin
                check_val("sb_underflow", BEAT_W'(sb_q.size()), ONE);
            end else begin
                check_val("beat_data", bus.relu_data_w, sb_q[0].d);
                check_val("beat_last", BEAT_W'(bus.relu_last_w), BEAT_W'(sb_q[0].l));
                if (bus.relu_ready_w) begin
                    void'(sb_q.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CHN*IN_W-1:0]  ps;
        logic [CHN*OUT_W-1:0] w;
        int c1, c2, base;

        bus.part_sum_w    = '0;
        bus.part_sum_v_w  = 1'b0;
        bus.final_out_v_w = 1'b0;
        bus.shift_w       = '0;
        bus.relu_ready_w  = 1'b1;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_vld", BEAT_W'(bus.relu_data_v_w), ZERO);
        check_val("rst_data", bus.relu_data_w, ZERO);
        check_val("rst_last", BEAT_W'(bus.relu_last_w), ZERO);
        check_val("rst_drop", BEAT_W'(drop_err_w), ZERO);
        check_val("rst_in_ready", BEAT_W'(bus.in_ready_w), ONE);
        rst = 1'b1;

        // Uniform 0x0100 >> 4 = 0x10 everywhere; beat 0 two edges after the drive edge
        ps = '0;
        for (int c = 0; c < CHN; c++) ps[c*IN_W +: IN_W] = 16'h0100;
        drive_word(ps, 4'd4, c1);
        check_val("lat_conv_vld", BEAT_W'(bus.relu_data_v_w), ZERO);
        @(posedge clk); #1;
        check_val("lat_beat0_vld", BEAT_W'(bus.relu_data_v_w), ONE);
        check_val("uniform_beat0", bus.relu_data_w, {16{8'h10}});
        drain();

        // Boundary channel values, shift 0 and shift 4
        ps = rand_ps();
        ps[63:0] = 64'h07F0_7FFF_FFFF_8000;
        drive_word(ps, 4'd0, c1);
        @(posedge clk); #1;
        check_val("bound_sh0", BEAT_W'(bus.relu_data_w[31:0]), BEAT_W'(32'h7F7F_0000));
        drain();
        ps = rand_ps();
        ps[63:0] = 64'h07F0_7FFF_FFFF_8000;
        drive_word(ps, 4'd4, c1);
        @(posedge clk); #1;
        check_val("bound_sh4", BEAT_W'(bus.relu_data_w[31:0]), BEAT_W'(32'h7F7F_0000));
        drain();

        // Backpressure on beat 1
        ps = rand_ps();
        w  = model_word(ps, 6);
        base = hs_cnt;
        drive_word(ps, 4'd6, c1);
        for (int t = 0; t < 50 && hs_cnt < base + 1; t++) @(posedge clk);
        #1;
        bus.relu_ready_w = 1'b0;
        repeat (3) begin
            check_val("hold_vld", BEAT_W'(bus.relu_data_v_w), ONE);
            check_val("hold_data", bus.relu_data_w, w[BEAT_W +: BEAT_W]);
            @(posedge clk); #1;
        end
        bus.relu_ready_w = 1'b1;
        drain();
        check_val("hold_total", BEAT_W'(hs_cnt - base), BEAT_W'(NBEAT));

        // Non-final valid in IDLE is ignored
        @(posedge clk); #1;
        bus.part_sum_w    = rand_ps();
        bus.shift_w       = 4'd3;
        bus.part_sum_v_w  = 1'b1;
        bus.final_out_v_w = 1'b0;
        @(posedge clk); #1;
        bus.part_sum_v_w  = 1'b0;
        check_val("nonfinal_rdy", BEAT_W'(bus.in_ready_w), ONE);
        @(posedge clk); #1;
        check_val("nonfinal_vld", BEAT_W'(bus.relu_data_v_w), ZERO);
        check_val("nonfinal_drop", BEAT_W'(drop_err_w), ZERO);

        // Final word during SEND is dropped and flagged; in-flight word unaffected
        drive_word(rand_ps(), 4'd5, c1);
        @(posedge clk); #1;
        bus.part_sum_w    = rand_ps();
        bus.part_sum_v_w  = 1'b1;
        bus.final_out_v_w = 1'b1;
        @(posedge clk); #1;
        bus.final_out_v_w = 1'b0;
        @(posedge clk); #1;
        bus.part_sum_v_w  = 1'b0;
        check_val("drop_set", BEAT_W'(drop_err_w), ONE);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_val("drop_sticky", BEAT_W'(drop_err_w), ONE);
        check_val("drop_idle_rdy", BEAT_W'(bus.in_ready_w), ONE);

        // Reset during beat 2, then capture on the first edge after release
        base = hs_cnt;
        drive_word(rand_ps(), 4'd2, c1);
        for (int t = 0; t < 50 && hs_cnt < base + 2; t++) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("midrst_vld", BEAT_W'(bus.relu_data_v_w), ZERO);
        check_val("midrst_data", bus.relu_data_w, ZERO);
        check_val("midrst_last", BEAT_W'(bus.relu_last_w), ZERO);
        check_val("midrst_drop", BEAT_W'(drop_err_w), ZERO);
        sb_q.delete();
        @(posedge clk); #1;
        check_val("midrst_rdy", BEAT_W'(bus.in_ready_w), ONE);
        ps = rand_ps();
        bus.part_sum_w    = ps;
        bus.shift_w       = 4'd1;
        bus.part_sum_v_w  = 1'b1;
        bus.final_out_v_w = 1'b1;
        push_word(ps, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        bus.part_sum_v_w  = 1'b0;
        bus.final_out_v_w = 1'b0;
        check_val("post_rst_capture", BEAT_W'(bus.in_ready_w), ZERO);
        @(posedge clk); #1;
        check_val("post_rst_vld", BEAT_W'(bus.relu_data_v_w), ONE);
        drain();

        // Back-to-back words with ready held high
        drive_word(rand_ps(), 4'd1, c1);
        drive_word(rand_ps(), 4'd7, c2);
        check_val("b2b_period", BEAT_W'(c2 - c1), BEAT_W'(6));
        check_val("b2b_gap_vld", BEAT_W'(bus.relu_data_v_w), ZERO);
        @(posedge clk); #1;
        check_val("b2b_second_vld", BEAT_W'(bus.relu_data_v_w), ONE);
        drain();

        // Random words and shifts under random backpressure
        fork
            begin
                for (int n = 0; n < 5; n++) drive_word(rand_ps(), 4'($urandom_range(15, 0)), c1);
            end
            begin
                repeat (150) begin
                    @(posedge clk); #1;
                    bus.relu_ready_w = 1'($urandom_range(1, 0));
                end
                bus.relu_ready_w = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
